// File: rtl/in_xif.sv
// Shared coprocessor-interface types for the FPU result path.
`default_nettype none

`ifndef X_ID_WIDTH
`define X_ID_WIDTH 4
`endif

package in_xif;

  localparam int X_ID_W = `X_ID_WIDTH;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic [X_ID_W-1:0] id;
    logic [XLEN-1:0]   data;
    logic [4:0]        rd;
    logic              we;
    logic              exc;
    logic [5:0]        exccode;
  } x_result_t;

  typedef struct packed {
    logic [X_ID_W-1:0] id;
    logic              commit_kill;
  } x_commit_t;

endpackage

`default_nettype wire

// File: rtl/rvfpm_result_fifo.sv
// ============================================================================
// rvfpm_result_fifo - FPU result buffer with commit-kill squashing | rev 1.0
// ============================================================================
`default_nettype none

module rvfpm_result_fifo
  import in_xif::*;
#(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = `X_ID_WIDTH
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  x_result_t                  in_result,
  input  logic                       commit_valid,
  input  x_commit_t                  commit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output x_result_t                  out_result,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_bad
    $error("rvfpm_result_fifo: DEPTH must be a power of two >= 2");
  end
  if (X_ID_WIDTH < 1 || X_ID_WIDTH > X_ID_W) begin : g_id_width_bad
    $error("rvfpm_result_fifo: X_ID_WIDTH out of range for x_result_t.id");
  end

  x_result_t        mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] live_next;
  logic [DEPTH-1:0] kill_hit;
  logic             push;
  logic             pop;
  logic             kill_en;
  logic             in_kill;

  assign full       = (count == DEPTH_CNT);
  assign empty      = (count == '0);
  assign in_ready   = !full;
  assign out_result = mem[rd_ptr];
  assign out_valid  = !empty && live[rd_ptr];

  assign push = in_valid && in_ready;
  // A dead head leaves without waiting for the core.
  assign pop  = !empty && (out_ready || !live[rd_ptr]);

  assign kill_en = commit_valid && commit.commit_kill;
  assign in_kill = kill_en &&
                   (in_result.id[X_ID_WIDTH-1:0] == commit.id[X_ID_WIDTH-1:0]);

  for (genvar i = 0; i < DEPTH; i++) begin : g_kill
    assign kill_hit[i] = kill_en &&
                         (mem[i].id[X_ID_WIDTH-1:0] == commit.id[X_ID_WIDTH-1:0]);
  end

  // Push and pop never target the same slot: push needs !full, pop needs !empty.
  always_comb begin
    live_next = live & ~kill_hit;
    if (pop) begin
      live_next[rd_ptr] = 1'b0;
    end
    if (push) begin
      live_next[wr_ptr] = !in_kill;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live   <= '0;
    end else begin
      live <= live_next;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (push) begin
      mem[wr_ptr] <= in_result;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rvfpm_result_fifo.sv
// Bench for rvfpm_result_fifo: queue-based reference model plus directed scenarios.
`default_nettype none

module tb_rvfpm_result_fifo;
  import in_xif::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          ck = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  x_result_t     in_result;
  logic          commit_valid;
  x_commit_t     commit;
  logic          out_valid;
  logic          out_ready;
  x_result_t     out_result;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  rvfpm_result_fifo #(.DEPTH(DEPTH), .X_ID_WIDTH(X_ID_W)) dut (
    .ck           (ck),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .commit_valid (commit_valid),
    .commit       (commit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  always #5 ck = ~ck;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of buffered results, each with a live flag.
  typedef struct {
    logic [X_ID_W-1:0] id;
    logic [31:0]       data;
    bit                live;
  } ent_t;

  ent_t              q[$];
  ent_t              e;
  int                got[$];
  bit                do_pop;
  bit                do_push;
  bit                kill;
  bit                pend_ov = 1'b0;
  logic [X_ID_W-1:0] pend_id = '0;
  bit                exp_ov;

  always @(posedge ck) begin
    if (rst && pend_ov && out_ready) got.push_back(int'(pend_id));
    if (!rst) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && (!q[0].live || out_ready);
      do_push = in_valid && (q.size() < DEPTH);
      kill    = commit_valid && commit.commit_kill;
      if (kill) foreach (q[i]) if (q[i].id == commit.id) q[i].live = 1'b0;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.id   = in_result.id;
        e.data = in_result.data;
        e.live = !(kill && (in_result.id == commit.id));
        q.push_back(e);
      end
    end
    #2;
    exp_ov = (q.size() > 0) && q[0].live;
    check("count",    count,     q.size());
    check("empty",    empty,     q.size() == 0);
    check("full",     full,      q.size() == DEPTH);
    check("in_ready", in_ready,  q.size() != DEPTH);
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      check("out_id",   out_result.id,   q[0].id);
      check("out_data", out_result.data, q[0].data);
    end
    pend_ov = out_valid;
    pend_id = out_result.id;
  end

  task automatic drive(input bit iv, input int id, input bit ordy,
                       input bit cv, input bit kl, input int kid);
    in_valid            = iv;
    in_result           = '0;
    in_result.id        = X_ID_W'(id);
    in_result.data      = 32'hD000_0000 + id;
    in_result.rd        = 5'(id);
    out_ready           = ordy;
    commit_valid        = cv;
    commit.commit_kill  = kl;
    commit.id           = X_ID_W'(kid);
    @(posedge ck);
    #3;
    in_valid           = 1'b0;
    out_ready          = 1'b0;
    commit_valid       = 1'b0;
    commit.commit_kill = 1'b0;
  endtask

  task automatic check_got(input string nm, input int n,
                           input int a0, input int a1, input int a2,
                           input int a3, input int a4);
    int exp_arr[5];
    exp_arr = '{a0, a1, a2, a3, a4};
    check({nm, "_n"}, got.size(), n);
    for (int k = 0; k < n && k < got.size(); k++)
      check($sformatf("%s_%0d", nm, k), got[k], exp_arr[k]);
    got.delete();
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_result = '0;
    out_ready = 1'b0;
    commit_valid = 1'b0;
    commit = '0;
    @(posedge ck); #3;
    @(posedge ck); #3;
    rst = 1'b1;
    check("rst_count", count, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_iready", in_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);

    // Three back-to-back pushes, core stalled.
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 2, 0, 0, 0, 0);
    drive(1, 3, 0, 0, 0, 0);
    check("t1_count", count, 3);
    check("t1_ovalid", out_valid, 1);
    check("t1_id", out_result.id, 1);
    check("t1_model", q.size(), 3);

    // Fill, hold a fifth, release one slot, then drain in order.
    drive(1, 4, 0, 0, 0, 0);
    check("t2_full", full, 1);
    check("t2_iready", in_ready, 0);
    drive(1, 5, 0, 0, 0, 0);
    check("t2_blocked", count, 4);
    drive(1, 5, 1, 0, 0, 0);
    check("t2_pop_count", count, 3);
    check("t2_pop_iready", in_ready, 1);
    drive(1, 5, 0, 0, 0, 0);
    check("t2_refill", count, 4);
    for (int k = 0; k < 4; k++) drive(0, 0, 1, 0, 0, 0);
    check("t2_empty", empty, 1);
    check_got("t2_order", 5, 1, 2, 3, 4, 5);

    // Kill a middle entry.
    drive(1, 5, 0, 0, 0, 0);
    drive(1, 6, 0, 0, 0, 0);
    drive(1, 7, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 6);
    check("t3_after_kill", count, 3);
    drive(0, 0, 1, 0, 0, 0);
    check("t3_count2", count, 2);
    check("t3_dead_head", out_valid, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("t3_count1", count, 1);
    check("t3_head7", out_result.id, 7);
    drive(0, 0, 1, 0, 0, 0);
    check("t3_count0", count, 0);
    check_got("t3_order", 2, 5, 7, 0, 0, 0);

    // Push and kill of the same id in one cycle.
    drive(1, 9, 0, 1, 1, 9);
    check("t4_count", count, 1);
    check("t4_ovalid", out_valid, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("t4_empty", empty, 1);
    check_got("t4_none", 0, 0, 0, 0, 0, 0);

    // Transfer of the head in the same cycle as its kill.
    drive(1, 4, 0, 0, 0, 0);
    drive(1, 8, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 1, 4);
    check("t5_count", count, 1);
    check("t5_head8", out_result.id, 8);
    check_got("t5_xfer", 1, 4, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    check_got("t5_rest", 1, 8, 0, 0, 0, 0);

    // Commit without kill leaves state alone.
    drive(1, 3, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 3);
    check("t6_count", count, 1);
    check("t6_ovalid", out_valid, 1);
    drive(0, 0, 1, 0, 0, 0);
    check_got("t6_deliv", 1, 3, 0, 0, 0, 0);

    // Reset while pushing and popping.
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 2, 0, 0, 0, 0);
    check("t7_pre", count, 2);
    rst = 1'b0;
    drive(1, 7, 1, 0, 0, 0);
    rst = 1'b1;
    check("t7_count", count, 0);
    check("t7_ovalid", out_valid, 0);
    check("t7_iready", in_ready, 1);
    check("t7_empty", empty, 1);
    drive(0, 0, 1, 0, 0, 0);
    check("t7_still_empty", empty, 1);
    check_got("t7_none", 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rvfpm_result_fifo.md
RVFPM_RESULT_FIFO -- requirements
Module: rvfpm_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered results (power of two, >=2).
REQ-002 SHALL have parameter X_ID_WIDTH, default `X_ID_WIDTH, instruction id width.
REQ-003 SHALL have port ck  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  FPU result valid (from rvfpm result_valid).
REQ-006 SHALL have port in_ready  output  1  buffer can accept (to rvfpm result_ready).
REQ-007 SHALL have port in_result  input  x_result_t  FPU result payload.
REQ-008 SHALL have port commit_valid  input  1  core commit strobe.
REQ-009 SHALL have port commit  input  x_commit_t  commit id and commit_kill.
REQ-010 SHALL have port out_valid  output  1  result presented to core.
REQ-011 SHALL have port out_ready  input  1  core accepts result.
REQ-012 SHALL have port out_result  output  x_result_t  head entry payload.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries, killed included.
REQ-014 SHALL have ports full, empty  output  1 each  count==DEPTH, count==0.

Function
REQ-015 Push SHALL occur on rising edge when in_valid && in_ready; entry stores payload plus live flag=1.
REQ-016 in_ready SHALL equal !full, registered-state only; no combinational path from out_ready.
REQ-017 out_valid SHALL equal !empty && head.live; out_result SHALL be head payload, unregistered read of storage.
REQ-018 Pop SHALL occur on edge when out_valid && out_ready, or when !empty && !head.live (silent drop, one entry per cycle).
REQ-019 Latency SHALL be one cycle: entry pushed at edge N is visible at out_valid after edge N if buffer was empty; no same-cycle bypass.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; allowed at full only if pop happens (in_ready still 0 at full, so push cannot).
REQ-021 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-022 On commit_valid && commit.commit_kill, every stored entry with id==commit.id SHALL have live cleared at that edge.
REQ-023 An entry pushed in the same cycle as a matching kill SHALL be stored with live=0.
REQ-024 A head entry transferred (out_valid && out_ready) in the same cycle as its kill SHALL count as delivered; kill has no further effect.
REQ-025 commit_valid without commit_kill SHALL not alter state.
REQ-026 Push when full SHALL not occur (in_ready=0); pop when empty SHALL not occur; neither corrupts pointers.
REQ-027 Payload fields SHALL pass through unmodified, id compared on X_ID_WIDTH bits only.

Reset
REQ-028 When rst==0 at a rising edge: pointers=0, count=0, all live=0; outputs thereafter in_ready=1, out_valid=0, empty=1, full=0, count=0.
REQ-029 Reset mid-operation SHALL discard all entries, including one being pushed or popped in that cycle.
REQ-030 Payload storage SHALL not require reset; out_result is don't-care while out_valid=0.

Structure
REQ-031 x_result_t and x_commit_t SHALL come from the shared in_xif package; no new typedefs.
REQ-032 DEPTH legality check SHALL be an elaboration-time assertion in the module.
REQ-033 No sub-module; storage, pointers and kill-compare live in this module.

Verification
REQ-034 Reset, then push ids 1,2,3 on consecutive cycles with out_ready=0 -> count=3, out_valid=1, out_result.id=1.
REQ-035 Push 4 results with DEPTH=4, out_ready=0 -> full=1, in_ready=0; fifth in_valid held, then one pop -> in_ready=1 next cycle, fifth accepted, order 1..5 preserved.
REQ-036 Buffer holds ids 5,6,7; kill id 6 -> core receives 5 then 7; id 6 dropped in one silent cycle, count decrements 3->2->1->0 correctly.
REQ-037 Push id 9 same cycle as kill id 9 -> out_valid never asserts for id 9; empty=1 two cycles later.
REQ-038 Head id 4 transferred same cycle as kill id 4 -> transfer counted, count decrements by 1 only.
REQ-039 Fill to 2 entries, assert rst=0 for one cycle while in_valid=1 and out_ready=1 -> count=0, out_valid=0, in_ready=1 after reset edge.
